// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
//   Iterative radix-2 restoring divider that produces one quotient bit per
//   clock. A sequencer requests a division with a start pulse and waits for
//   the one-cycle done pulse. The quotient, remainder and divide-by-zero flag
//   hold their values until the next accepted request reaches FIN.
//
//   Optional build macro: DIVIDER_SEQ_SIGNED_EN
//     undefined : unsigned operands, IDLE -> CALC -> FIN, latency N+1
//     defined   : two's-complement operands. Magnitudes are taken at
//                 acceptance, and a FIX state between CALC and FIN applies
//                 the signs. The quotient truncates toward zero. Latency N+2.
//   A divide by zero always goes straight to FIN and finishes in one cycle.
// -----------------------------------------------------------------------------
module divider_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int             CW       = $clog2(N);
  localparam logic [CW-1:0]  CNT_INIT = CW'(N - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
`ifdef DIVIDER_SEQ_SIGNED_EN
  localparam logic [N-1:0]   ONE      = N'(1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC,
`ifdef DIVIDER_SEQ_SIGNED_EN
    FIX,
`endif
    FIN
  } state_e;

  state_e state_q, state_d;

  // Working registers. The divisor is D, the quotient shift register is Q,
  // the partial remainder is R, and the iteration counter is cnt.
  // After every step R is below D, so N bits are enough to hold it. Only the
  // shifted trial value needs the extra (N+1)th bit.
  logic [N-1:0]  d_q,   d_d;
  logic [N-1:0]  qw_q,  qw_d;
  logic [N-1:0]  r_q,   r_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Result registers that drive the outputs.
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

`ifdef DIVIDER_SEQ_SIGNED_EN
  // Sign corrections, recorded at acceptance and applied in FIX.
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [N-1:0]  a_mag, b_mag;
`endif

  // One restoring step.
  logic [N:0]    r_shift;
  logic          r_ge;
  logic [N-1:0]  r_step;
  logic [N-1:0]  q_step;

  // Restoring step: shift the next dividend bit into R, then subtract D if
  // the result fits.
  always_comb begin
    r_shift = {r_q, qw_q[N-1]};
    r_ge    = (r_shift >= {1'b0, d_q});
    // The difference is below D, so the low N bits hold the exact result.
    r_step  = r_ge ? (r_shift[N-1:0] - d_q) : r_shift[N-1:0];
    q_step  = {qw_q[N-2:0], r_ge};
  end

`ifdef DIVIDER_SEQ_SIGNED_EN
  // Operand magnitudes. The most-negative value maps to itself, and as an
  // unsigned number that is its true magnitude.
  always_comb begin
    a_mag = dividend[N-1] ? (~dividend + ONE) : dividend;
    b_mag = divisor[N-1]  ? (~divisor  + ONE) : divisor;
  end
`endif

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. Any path
    // that skips an assignment then keeps its value in the flop, instead of
    // creating a latch.
    state_d = state_q;
    d_d     = d_q;
    qw_d    = qw_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SEQ_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero skips the iterations and posts its result now.
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end else begin
`ifdef DIVIDER_SEQ_SIGNED_EN
            d_d       = b_mag;
            qw_d      = a_mag;
            neg_quo_d = dividend[N-1] ^ divisor[N-1];
            neg_rem_d = dividend[N-1];
`else
            d_d       = divisor;
            qw_d      = dividend;
`endif
            r_d     = '0;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        busy = 1'b1;
        r_d  = r_step;
        qw_d = q_step;
        if (cnt_q == '0) begin
`ifdef DIVIDER_SEQ_SIGNED_EN
          state_d = FIX;
`else
          // Load the final step directly into the result registers, so the
          // results are already valid while done is high.
          quo_d   = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
          state_d = FIN;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

`ifdef DIVIDER_SEQ_SIGNED_EN
      FIX: begin
        busy    = 1'b1;
        // The quotient sign follows the operand signs. The remainder sign
        // follows the dividend.
        quo_d   = neg_quo_q ? (~qw_q + ONE) : qw_q;
        rem_d   = neg_rem_q ? (~r_q  + ONE) : r_q;
        dbz_d   = 1'b0;
        state_d = FIN;
      end
`endif

      FIN: begin
        // A start request here is ignored. The next one is accepted in IDLE.
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential blocks use non-blocking assignments only. Every flop
      // then samples values from before the edge, whatever the order in
      // which the blocks are evaluated.
      state_q <= state_d;
    end
  end

  // Working and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the working registers are reset as well as the outputs. An
      // aborted division then leaves no partial value behind, and
      // simulation starts from known values instead of X.
      d_q       <= '0;
      qw_q      <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
`ifdef DIVIDER_SEQ_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      d_q       <= d_d;
      qw_q      <= qw_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
`ifdef DIVIDER_SEQ_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
